// File: rtl/ste_avg_pkg.sv
// Shared types, constants and helpers for the multi-channel IIR averager.
// acc_t/diff_t describe the default 16-bit sample, 8-guard-bit configuration.
package ste_avg_pkg;

   localparam int unsigned DATA_W_DEF  = 16;
   localparam int unsigned GUARD_W_DEF = 8;
   localparam int unsigned SETTLE_MUL  = 4;

   typedef logic [DATA_W_DEF+GUARD_W_DEF-1:0]      acc_t;
   typedef logic signed [DATA_W_DEF+GUARD_W_DEF:0] diff_t;

   function automatic int unsigned clamp_k(int unsigned k, int unsigned k_max);
      return (k > k_max) ? k_max : k;
   endfunction

endpackage

// File: rtl/ste_avg_settle_cnt.sv
// Per-channel settle counter: counts averaged updates since priming or the last
// coefficient change, and flags the channel settled once SETTLE_MUL << keff is reached.
module ste_avg_settle_cnt
   import ste_avg_pkg::*;
#(
   parameter int unsigned K_MAX = 12,
   parameter int unsigned K_W   = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clear_i,
   input  logic           rebase_i,
   input  logic           fill_i,
   input  logic           prime_i,
   input  logic           step_i,
   input  logic [K_W-1:0] keff_i,
   output logic           settled_o
);

   localparam int unsigned     CntW   = K_MAX + 3;
   localparam logic [CntW-1:0] CntMax = '1;
   localparam logic [CntW-1:0] CntOne = CntW'(1);
   localparam logic [CntW-1:0] Mul    = CntW'(SETTLE_MUL);

   logic [CntW-1:0] cnt_q, cnt_d, base;

   // A coefficient change restarts the count, but the update that caused it still counts.
   always_comb begin
      base  = rebase_i ? '0 : cnt_q;
      cnt_d = base;
      if (clear_i) begin
         cnt_d = '0;
      end else if (fill_i) begin
         cnt_d = CntMax;
      end else if (prime_i) begin
         cnt_d = '0;
      end else if (step_i && (base != CntMax)) begin
         cnt_d = base + CntOne;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign settled_o = (cnt_q >= (Mul << keff_i));

endmodule

// File: rtl/ste_avg_iir_mc.sv
// Multi-channel first-order IIR averager, alpha = 2^-k, with priming, bypass and settle flags.
// Build option: define STE_AVG_ROUND_EN for round-half-up output, otherwise truncation.
module ste_avg_iir_mc
   import ste_avg_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned CH_N    = 4,
   parameter int unsigned GUARD_W = GUARD_W_DEF,
   parameter int unsigned K_MAX   = 12,
   parameter int unsigned K_W     = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATA_W-1:0]       din_i,
   input  logic [$clog2(CH_N)-1:0] din_ch_i,
   input  logic                    din_valid_i,
   output logic                    din_ready_o,
   input  logic                    avg_clr_i,
   input  logic                    avg_en_i,
   input  logic [K_W-1:0]          k_i,
   output logic [DATA_W-1:0]       dout_o,
   output logic [$clog2(CH_N)-1:0] dout_ch_o,
   output logic                    dout_valid_o,
   input  logic                    dout_ready_i,
   output logic [CH_N-1:0]         settled_o
);

   localparam int unsigned AccW = DATA_W + GUARD_W;
   localparam int unsigned ChW  = $clog2(CH_N);

   logic              s1_valid_q;
   logic [DATA_W-1:0] s1_din_q;
   logic [ChW-1:0]    s1_ch_q;
   logic              s1_en_q;
   logic [K_W-1:0]    s1_keff_q;
   logic [K_W-1:0]    keff_q;
   logic [AccW-1:0]   acc_q [CH_N];
   logic [CH_N-1:0]   primed_q;
   logic [DATA_W-1:0] dout_q;
   logic [ChW-1:0]    dout_ch_q;
   logic              dout_valid_q;

   logic              accept, s2_adv, keff_chg, load;
   logic [AccW-1:0]   acc_cur, din_sh, acc_new, acc_out;
   logic signed [AccW:0] diff, diff_sh;
   logic [DATA_W-1:0] dout_new;

   assign din_ready_o = ~avg_clr_i & (~s1_valid_q | ~dout_valid_q | dout_ready_i);
   assign accept      = din_valid_i & din_ready_o;
   assign s2_adv      = ~avg_clr_i & s1_valid_q & (~dout_valid_q | dout_ready_i);
   assign keff_chg    = (s1_keff_q != keff_q);
   assign load        = ~s1_en_q | ~primed_q[s1_ch_q];

   // The accumulator stays inside [0, max << GUARD_W], so the truncating add cannot wrap.
   always_comb begin
      acc_cur = acc_q[s1_ch_q];
      din_sh  = {s1_din_q, {GUARD_W{1'b0}}};
      diff    = $signed({1'b0, din_sh}) - $signed({1'b0, acc_cur});
      diff_sh = diff >>> s1_keff_q;
      acc_new = load ? din_sh : (acc_cur + AccW'(diff_sh));
`ifdef STE_AVG_ROUND_EN
      acc_out = acc_new + (AccW'(1) << (GUARD_W - 1));
`else
      acc_out = acc_new;
`endif
      dout_new = DATA_W'(acc_out >> GUARD_W);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_din_q     <= '0;
         s1_ch_q      <= '0;
         s1_en_q      <= 1'b0;
         s1_keff_q    <= '0;
         keff_q       <= '0;
         primed_q     <= '0;
         dout_q       <= '0;
         dout_ch_q    <= '0;
         dout_valid_q <= 1'b0;
         for (int i = 0; i < CH_N; i++) acc_q[i] <= '0;
      end else if (avg_clr_i) begin
         s1_valid_q   <= 1'b0;
         dout_valid_q <= 1'b0;
         primed_q     <= '0;
         for (int i = 0; i < CH_N; i++) acc_q[i] <= '0;
      end else begin
         if (accept) begin
            s1_valid_q <= 1'b1;
            s1_din_q   <= din_i;
            s1_ch_q    <= din_ch_i;
            s1_en_q    <= avg_en_i;
            s1_keff_q  <= K_W'(clamp_k(32'(k_i), K_MAX));
         end else if (s2_adv) begin
            s1_valid_q <= 1'b0;
         end
         if (s2_adv) begin
            acc_q[s1_ch_q]    <= acc_new;
            primed_q[s1_ch_q] <= 1'b1;
            keff_q            <= s1_keff_q;
            dout_q            <= dout_new;
            dout_ch_q         <= s1_ch_q;
            dout_valid_q      <= 1'b1;
         end else if (dout_ready_i) begin
            dout_valid_q <= 1'b0;
         end
      end
   end

   for (genvar c = 0; c < CH_N; c++) begin : g_settle
      logic hit;
      assign hit = s2_adv & (s1_ch_q == ChW'(c));

      ste_avg_settle_cnt #(
         .K_MAX (K_MAX),
         .K_W   (K_W)
      ) u_settle_cnt (
         .clk       (clk),
         .rst_n     (rst_n),
         .clear_i   (avg_clr_i),
         .rebase_i  (s2_adv & keff_chg),
         .fill_i    (hit & ~s1_en_q),
         .prime_i   (hit & s1_en_q & ~primed_q[c]),
         .step_i    (hit & s1_en_q & primed_q[c]),
         .keff_i    (keff_q),
         .settled_o (settled_o[c])
      );
   end

   assign dout_o       = dout_q;
   assign dout_ch_o    = dout_ch_q;
   assign dout_valid_o = dout_valid_q;

endmodule
